// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one sequential Booth multiplier among NREQ clients.
// The winner's operands are latched at grant, then streamed A then B onto the load bus, and the product is returned with a 1-cycle ack.
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         ack,
  output logic                    err,
  output logic [2*WIDTH-1:0]      result,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_data,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_prod
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [IDW-1:0]            ptr;
  logic                      just_done;
  logic [CW-1:0]             cnt;
  logic [WIDTH-1:0]          b_lat;
  logic [NREQ-1:0]           mask, elig;
  logic                      found;
  logic [IDW-1:0]            win, idx;
  logic                      timeout;
  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  assign timeout = (cnt == CW'(TIMEOUT-1));

  // Round-robin search starting just after the last owner; the last owner is
  // hidden for one IDLE cycle so a held req does not see its own stale level.
  always_comb begin
    mask = '0;
    if (just_done) mask[ptr] = 1'b1;
    elig  = req & ~mask;
    found = 1'b0;
    win   = '0;
    idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == IDW'(NREQ-1)) ? '0 : idx + IDW'(1);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (found) state_nxt = S_LOAD_A;
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_WAIT;
      S_WAIT:   if (mul_done || timeout) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered on the edge that enters the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack       <= '0;
      err       <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      mul_start <= 1'b0;
      mul_data  <= '0;
      ptr       <= IDW'(NREQ-1);
      just_done <= 1'b0;
      cnt       <= '0;
      b_lat     <= '0;
    end else begin
      ack       <= '0;
      err       <= 1'b0;
      mul_start <= 1'b0;
      just_done <= 1'b0;
      case (state)
        S_IDLE: if (found) begin
          grant_id  <= win;
          b_lat     <= b_arr[win];
          mul_data  <= a_arr[win];
          mul_start <= 1'b1;
          busy      <= 1'b1;
        end
        S_LOAD_A: mul_data <= b_lat;
        S_LOAD_B: cnt <= '0;
        S_WAIT: begin
          if (mul_done) begin
            result        <= mul_prod;
            ack[grant_id] <= 1'b1;
          end else if (timeout) begin
            result        <= '0;
            err           <= 1'b1;
            ack[grant_id] <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          ptr       <= grant_id;
          busy      <= 1'b0;
          just_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural multiplier that raises done in a chosen WAIT cycle.
module tb_booth_mul_arbiter;
  localparam int NREQ = 4, IDW = 2, WIDTH = 16, TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic [2*WIDTH-1:0]    result;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic                  mul_start;
  logic [WIDTH-1:0]      mul_data;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_prod;

  int nchk = 0, nfail = 0;
  int done_n;
  logic extra_done;

  // multiplier model state
  logic [WIDTH-1:0] m_a;
  int   m_cnt;
  logic m_arm;

  always #5 clk = ~clk;

  booth_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .err(err), .result(result), .busy(busy), .grant_id(grant_id),
    .mul_start(mul_start), .mul_data(mul_data), .mul_done(mul_done), .mul_prod(mul_prod)
  );

  // Done is high during WAIT cycle done_n (0 = never).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_arm <= 1'b0; m_cnt <= 0; m_a <= '0; mul_prod <= '0;
    end else if (mul_start) begin
      m_a <= mul_data; m_cnt <= 0; m_arm <= 1'b1;
    end else if (m_arm) begin
      if (m_cnt == 0) mul_prod <= 32'($signed(m_a)) * 32'($signed(mul_data));
      m_cnt <= m_cnt + 1;
      if (done_n != 0 && m_cnt == done_n) m_arm <= 1'b0;
    end
  end

  assign mul_done = (m_arm && done_n != 0 && m_cnt == done_n) || extra_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge of the LOAD_A cycle.
  task automatic wait_start(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (mul_start) ok = 1'b1;
    end
    if (!ok) chk({tag, "_start_timeout"}, {63'd0, ok}, 64'd1);
  endtask

  // Counts cycles until ack; returns at the negedge of the ack cycle.
  task automatic wait_ack(input string tag, inout int cyc);
    logic ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) ok = 1'b1;
    end
    if (!ok) chk({tag, "_ack_timeout"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] exp_order [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    int cyc;
    rst = 1'b1; req = '0; req_a = '0; req_b = '0; done_n = 0; extra_done = 1'b0;
    do_reset();

    // reset state
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_misc", {err, grant_id, mul_start, mul_data}, 0);

    // basic op: 20 * -30, done in WAIT cycle 17
    req_a[0 +: 16] = 16'd20; req_b[0 +: 16] = 16'hFFE2; done_n = 17;
    req = 4'b0001;
    wait_start("t1");
    chk("t1_load_a", {busy, grant_id, mul_data}, {1'b1, 2'd0, 16'h0014});
    @(negedge clk);
    chk("t1_load_b", {mul_start, mul_data}, {1'b0, 16'hFFE2});
    cyc = 2;
    wait_ack("t1", cyc);
    chk("t1_latency", cyc, 20);
    chk("t1_ack", ack, 4'b0001);
    chk("t1_result", result, 32'hFFFFFDA8);
    chk("t1_err", err, 0);
    req = '0;
    @(negedge clk);
    chk("t1_ack_pulse", ack, 0);
    chk("t1_result_hold", {busy, result}, {1'b0, 32'hFFFFFDA8});

    // round robin with all requesting
    do_reset();
    done_n = 1; req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      cyc = 0;
      wait_ack("t2", cyc);
      chk($sformatf("t2_order%0d", k), ack, exp_order[k]);
      if (k == 5) req = '0;
      @(negedge clk);
      chk($sformatf("t2_idle%0d", k), {busy, ack}, 0);
      if (k < 5) begin
        @(negedge clk);
        chk($sformatf("t2_reload%0d", k), mul_start, 1);
      end
    end

    // mask after ack: get pointer to 0, then req0 stays one cycle past ack
    @(negedge clk);
    req = 4'b0001;
    cyc = 0;
    wait_ack("t3a", cyc);
    chk("t3_ack0", ack, 4'b0001);
    req = 4'b0101;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    chk("t3_grant2", {mul_start, grant_id}, {1'b1, 2'd2});
    cyc = 1;
    wait_ack("t3b", cyc);
    chk("t3_ack2", ack, 4'b0100);
    req = 4'b0001;
    cyc = 0;
    wait_ack("t3c", cyc);
    chk("t3_ack0b", ack, 4'b0001);
    @(negedge clk);
    chk("t3_masked_idle", {busy, mul_start}, 0);
    @(negedge clk);
    chk("t3_idle2", {busy, mul_start}, 0);
    @(negedge clk);
    chk("t3_regrant", {mul_start, grant_id}, {1'b1, 2'd0});
    cyc = 1;
    wait_ack("t3d", cyc);
    req = '0;
    @(negedge clk);

    // timeout, then a normal op
    done_n = 0; req = 4'b0001;
    wait_start("t4");
    cyc = 1;
    wait_ack("t4", cyc);
    chk("t4_latency", cyc, 67);
    chk("t4_ack", ack, 4'b0001);
    chk("t4_err", err, 1);
    chk("t4_result", result, 0);
    req = '0;
    @(negedge clk);
    req_a[0 +: 16] = 16'd5; req_b[0 +: 16] = 16'd7; done_n = 3; req = 4'b0001;
    wait_start("t4b");
    cyc = 1;
    wait_ack("t4b", cyc);
    chk("t4b_latency", cyc, 6);
    chk("t4b_res", {err, result}, {1'b0, 32'd35});
    req = '0;
    @(negedge clk);

    // reset mid-WAIT
    done_n = 0; req = 4'b0001;
    wait_start("t5");
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_async", {busy, mul_data, ack}, 0);
    @(negedge clk);
    req = 4'b1010; done_n = 2; rst = 1'b0;
    wait_start("t5");
    chk("t5_grant1", grant_id, 1);
    cyc = 1;
    wait_ack("t5", cyc);
    chk("t5_ack", ack, 4'b0010);
    chk("t5_latency", cyc, 5);
    req = '0;
    @(negedge clk);

    // done in LOAD_B and operand change after grant are ignored
    req_a[0 +: 16] = 16'd3; req_b[0 +: 16] = 16'hFFFC; done_n = 5; req = 4'b0001;
    wait_start("t6");
    req_a[0 +: 16] = 16'h7FFF;
    @(negedge clk);
    chk("t6_load_b", mul_data, 16'hFFFC);
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    chk("t6_no_early_ack", {ack, busy}, {4'b0000, 1'b1});
    cyc = 3;
    wait_ack("t6", cyc);
    chk("t6_latency", cyc, 8);
    chk("t6_result", {err, result}, {1'b0, 32'hFFFFFFF4});
    req = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
